// File: rtl/voice_allocator.sv
// Polyphony scheduler: shares NUM_VOICES generator slots among NUM_KEYS keys.
// Define VOICE_STEAL_EN to steal the oldest ACTIVE voice instead of dropping.
module voice_allocator #(
    parameter int NUM_KEYS       = 8,
    parameter int NUM_VOICES     = 4,
    parameter int KEY_W          = 3,
    parameter int AGE_W          = 8,
    parameter int RELEASE_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         key_down,
    output logic [NUM_VOICES-1:0]       voice_en,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       voice_releasing,
    output logic [NUM_KEYS-1:0]         key_granted,
    output logic                        steal_pulse,
    output logic                        drop_pulse
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int REL_W = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [REL_W-1:0] REL_LOAD = REL_W'(RELEASE_CYCLES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {FREE, ACTIVE, RELEASE} vstate_e;

    vstate_e            state_q [NUM_VOICES];
    vstate_e            state_d [NUM_VOICES];
    logic [KEY_W-1:0]   vkey_q  [NUM_VOICES];
    logic [KEY_W-1:0]   vkey_d  [NUM_VOICES];
    logic [AGE_W-1:0]   age_q   [NUM_VOICES];
    logic [AGE_W-1:0]   age_d   [NUM_VOICES];
    logic [REL_W-1:0]   cnt_q   [NUM_VOICES];
    logic [REL_W-1:0]   cnt_d   [NUM_VOICES];

    logic [NUM_KEYS-1:0] key_q, pend_on_q, pend_on_d, pend_off_q, pend_off_d;
    logic [NUM_KEYS-1:0] rise, fall, pon, srv_on, srv_off, granted;
    logic                steal_q, steal_d, drop_q, drop_d;
    logic                off_hit, on_hit, hold_hit, own_hit;
    logic                free_hit, rel_hit, do_assign;
    logic [KEY_W-1:0]    off_k, on_k;
    logic [VW-1:0]       hold_v, free_v, rel_v, tgt;
`ifdef VOICE_STEAL_EN
    logic                old_hit;
    logic [VW-1:0]       old_v;
    logic [AGE_W-1:0]    old_age;
`endif

    always_comb begin
        rise     = key_down & ~key_q;
        fall     = ~key_down & key_q;
        granted  = '0;
        off_hit  = 1'b0;
        on_hit   = 1'b0;
        off_k    = '0;
        on_k     = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pend_off_q[k]) begin
                off_hit = 1'b1;
                off_k   = KEY_W'(k);
            end
            if (pend_on_q[k]) begin
                on_hit = 1'b1;
                on_k   = KEY_W'(k);
            end
        end

        hold_hit = 1'b0;
        own_hit  = 1'b0;
        free_hit = 1'b0;
        rel_hit  = 1'b0;
        hold_v   = '0;
        free_v   = '0;
        rel_v    = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (state_q[v] == ACTIVE) begin
                granted[vkey_q[v]] = 1'b1;
                if (vkey_q[v] == off_k) begin
                    hold_hit = 1'b1;
                    hold_v   = VW'(v);
                end
                if (vkey_q[v] == on_k) own_hit = 1'b1;
            end
            if (state_q[v] == FREE) begin
                free_hit = 1'b1;
                free_v   = VW'(v);
            end
            if (state_q[v] == RELEASE) begin
                rel_hit = 1'b1;
                rel_v   = VW'(v);
            end
        end

`ifdef VOICE_STEAL_EN
        // Oldest ACTIVE voice; strict compare keeps the lowest index on ties.
        old_hit = 1'b0;
        old_v   = '0;
        old_age = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (state_q[v] == ACTIVE && (!old_hit || age_q[v] > old_age)) begin
                old_hit = 1'b1;
                old_v   = VW'(v);
                old_age = age_q[v];
            end
        end
`endif

        for (int v = 0; v < NUM_VOICES; v++) begin
            state_d[v] = state_q[v];
            vkey_d[v]  = vkey_q[v];
            age_d[v]   = age_q[v];
            cnt_d[v]   = cnt_q[v];
            if (state_q[v] == ACTIVE && age_q[v] != AGE_MAX)
                age_d[v] = age_q[v] + 1'b1;
            if (state_q[v] == RELEASE) begin
                if (cnt_q[v] == '0) state_d[v] = FREE;
                else                cnt_d[v]   = cnt_q[v] - 1'b1;
            end
        end

        srv_on    = '0;
        srv_off   = '0;
        steal_d   = 1'b0;
        drop_d    = 1'b0;
        do_assign = 1'b0;
        tgt       = '0;
        if (off_hit) begin
            srv_off[off_k] = 1'b1;
            if (hold_hit) begin
                state_d[hold_v] = RELEASE;
                cnt_d[hold_v]   = REL_LOAD;
                age_d[hold_v]   = age_q[hold_v];
            end
        end else if (on_hit) begin
            srv_on[on_k] = 1'b1;
            if (!own_hit) begin
                if (free_hit) begin
                    do_assign = 1'b1;
                    tgt       = free_v;
                end else if (rel_hit) begin
                    do_assign = 1'b1;
                    tgt       = rel_v;
                end else begin
`ifdef VOICE_STEAL_EN
                    do_assign = 1'b1;
                    tgt       = old_v;
                    steal_d   = 1'b1;
`else
                    drop_d    = 1'b1;
`endif
                end
            end
        end
        if (do_assign) begin
            state_d[tgt] = ACTIVE;
            vkey_d[tgt]  = on_k;
            age_d[tgt]   = '0;
        end

        // A release arriving before its note-on was served cancels both.
        pon        = pend_on_q & ~srv_on;
        pend_on_d  = (pon | rise) & ~fall;
        pend_off_d = (pend_off_q & ~srv_off) | (fall & ~pon);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q      <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            steal_q    <= 1'b0;
            drop_q     <= 1'b0;
            state_q    <= '{default: FREE};
            vkey_q     <= '{default: '0};
            age_q      <= '{default: '0};
            cnt_q      <= '{default: '0};
        end else begin
            key_q      <= key_down;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            steal_q    <= steal_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            vkey_q     <= vkey_d;
            age_q      <= age_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        voice_en        = '0;
        voice_releasing = '0;
        voice_key       = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_en[v]                 = state_q[v] != FREE;
            voice_releasing[v]          = state_q[v] == RELEASE;
            voice_key[v*KEY_W +: KEY_W] = vkey_q[v];
        end
    end

    assign key_granted = granted;
    assign steal_pulse = steal_q;
    assign drop_pulse  = drop_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (RELEASE_CYCLES=16), both steal builds.
module tb_voice_allocator;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  key_down;
    logic [3:0]  voice_en;
    logic [11:0] voice_key;
    logic [3:0]  voice_releasing;
    logic [7:0]  key_granted;
    logic        steal_pulse;
    logic        drop_pulse;

    int n_vec = 0;
    int n_err = 0;

    voice_allocator #(.RELEASE_CYCLES(16)) dut (
        .clk             (clk),
        .reset           (rst),
        .key_down        (key_down),
        .voice_en        (voice_en),
        .voice_key       (voice_key),
        .voice_releasing (voice_releasing),
        .key_granted     (key_granted),
        .steal_pulse     (steal_pulse),
        .drop_pulse      (drop_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  kd;
        logic [3:0]  en;
        logic [11:0] vk;
        logic [7:0]  kg;
        logic [3:0]  rel;
        logic        stl;
        logic        drp;
    } vec_t;

    vec_t tv [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        key_down = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int cnt, ns, nd;

        tv[0]  = '{8'h00, 4'h0, 12'h000, 8'h00, 4'h0, 1'b0, 1'b0};
        tv[1]  = '{8'h04, 4'h0, 12'h000, 8'h00, 4'h0, 1'b0, 1'b0};
        tv[2]  = '{8'h04, 4'h1, 12'h002, 8'h04, 4'h0, 1'b0, 1'b0};
        tv[3]  = '{8'h0F, 4'h1, 12'h002, 8'h04, 4'h0, 1'b0, 1'b0};
        tv[4]  = '{8'h0F, 4'h3, 12'h002, 8'h05, 4'h0, 1'b0, 1'b0};
        tv[5]  = '{8'h0F, 4'h7, 12'h042, 8'h07, 4'h0, 1'b0, 1'b0};
        tv[6]  = '{8'h0F, 4'hF, 12'h642, 8'h0F, 4'h0, 1'b0, 1'b0};
        tv[7]  = '{8'h0B, 4'hF, 12'h642, 8'h0F, 4'h0, 1'b0, 1'b0};
        tv[8]  = '{8'h0B, 4'hF, 12'h642, 8'h0B, 4'h1, 1'b0, 1'b0};
        tv[9]  = '{8'h8B, 4'hF, 12'h642, 8'h0B, 4'h1, 1'b0, 1'b0};
        tv[10] = '{8'h8B, 4'hF, 12'h647, 8'h8B, 4'h0, 1'b0, 1'b0};
        tv[11] = '{8'h8B, 4'hF, 12'h647, 8'h8B, 4'h0, 1'b0, 1'b0};
        tv[12] = '{8'h8F, 4'hF, 12'h647, 8'h8B, 4'h0, 1'b0, 1'b0};
`ifdef VOICE_STEAL_EN
        tv[13] = '{8'h8F, 4'hF, 12'h657, 8'h8E, 4'h0, 1'b1, 1'b0};
        tv[14] = '{8'h8F, 4'hF, 12'h657, 8'h8E, 4'h0, 1'b0, 1'b0};
`else
        tv[13] = '{8'h8F, 4'hF, 12'h647, 8'h8B, 4'h0, 1'b0, 1'b1};
        tv[14] = '{8'h8F, 4'hF, 12'h647, 8'h8B, 4'h0, 1'b0, 1'b0};
`endif

        do_reset();
        chk("reset_state",
            {voice_en, voice_key, key_granted, voice_releasing,
             steal_pulse, drop_pulse}, 32'h0);
        for (int i = 0; i < 15; i++) begin
            key_down = tv[i].kd;
            tick();
            chk($sformatf("vec%0d", i),
                {2'b00, voice_en, voice_key, key_granted, voice_releasing,
                 steal_pulse, drop_pulse},
                {2'b00, tv[i].en, tv[i].vk, tv[i].kg, tv[i].rel,
                 tv[i].stl, tv[i].drp});
        end

        // Three simultaneous presses served one per cycle.
        do_reset();
        key_down = 8'h0B;
        tick();
        chk("multi_e0_en", voice_en, 4'h0);
        tick();
        chk("multi_e1", {voice_en, voice_key, key_granted}, {4'h1, 12'h000, 8'h01});
        tick();
        chk("multi_e2", {voice_en, voice_key, key_granted}, {4'h3, 12'h008, 8'h03});
        tick();
        chk("multi_e3", {voice_en, voice_key, key_granted}, {4'h7, 12'h0C8, 8'h0B});

        // Release tail length.
        do_reset();
        key_down = 8'h20;
        repeat (2) tick();
        chk("rel_on", {voice_en, voice_key, key_granted}, {4'h1, 12'h005, 8'h20});
        repeat (3) tick();
        key_down = 8'h00;
        tick();
        chk("rel_f0", {voice_en, voice_releasing}, {4'h1, 4'h0});
        tick();
        chk("rel_f1", {voice_releasing, key_granted}, {4'h1, 8'h00});
        cnt = voice_en[0] ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!voice_en[0]) break;
            cnt++;
        end
        chk("rel_len", cnt, 16);
        chk("rel_free", {voice_en, voice_releasing}, {4'h0, 4'h0});

        // Full voices, staggered presses, then one more key.
        do_reset();
        key_down = 8'h01;
        repeat (10) tick();
        key_down = 8'h03;
        repeat (10) tick();
        key_down = 8'h07;
        repeat (10) tick();
        key_down = 8'h0F;
        repeat (10) tick();
        chk("full_kg", key_granted, 8'h0F);
        key_down = 8'h8F;
        ns = 0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ns += int'(steal_pulse);
            nd += int'(drop_pulse);
        end
`ifdef VOICE_STEAL_EN
        chk("over_pulses", {ns[7:0], nd[7:0]}, {8'd1, 8'd0});
        chk("over_state", {voice_en, voice_key, key_granted}, {4'hF, 12'h68F, 8'h8E});
`else
        chk("over_pulses", {ns[7:0], nd[7:0]}, {8'd0, 8'd1});
        chk("over_state", {voice_en, voice_key, key_granted}, {4'hF, 12'h688, 8'h0F});
`endif

        // Asynchronous reset mid-cycle, key held through deassertion.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {voice_en, key_granted}, {4'h0, 8'h00});
        key_down = 8'h10;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_e0", voice_en, 4'h0);
        tick();
        chk("post_rst_e1", {voice_en, voice_key, key_granted}, {4'h1, 12'h004, 8'h10});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
